// File: rtl/output_arbiter.sv
// Output-port arbiter: round-robin selection among the VC buffers of one input
// port, gated by a credit counter that mirrors free slots in the next router.
module output_arbiter #(
  parameter int NUM_VC           = 4,
  parameter int DOWNSTREAM_DEPTH = 4,
  parameter int FLIT_SIZE        = 8,
  parameter int VC_W             = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_VC*FLIT_SIZE-1:0] vc_flit,
  input  logic [NUM_VC-1:0]           vc_is_new,
  input  logic                        credit_return,
  output logic [NUM_VC-1:0]           vc_grant,
  output logic [FLIT_SIZE-1:0]        flit_out,
  output logic                        flit_out_valid,
  output logic [VC_W-1:0]             flit_out_vc,
  output logic                        dbg_state,
  output logic [3:0]                  dbg_cnt
);

  // Handshake: a flit is offered while vc_is_new[i] is high; it is taken on the
  // edge that registers vc_grant[i], which then pulses for exactly one cycle.
  // flit_out_valid marks the same cycle; the link has no backpressure, credits
  // stand in for downstream ready.

  typedef enum logic {RUN = 1'b0, BLOCKED = 1'b1} state_t;

  localparam logic [3:0] DEPTH = 4'(DOWNSTREAM_DEPTH);

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic [VC_W-1:0]     rr, rr_next;
  logic [NUM_VC-1:0]   served, served_next;
  logic [NUM_VC-1:0]   eligible;
  logic [VC_W-1:0]     winner;
  logic                found;
  logic                send;
  logic                ret_ok;
  logic [NUM_VC-1:0]   grant_next;
  logic [FLIT_SIZE-1:0] flit_next;

  assign eligible  = vc_is_new & ~served;
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  // First eligible VC scanning upward from rr, wrapping at NUM_VC.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = int'(rr) + k;
      if (idx >= NUM_VC) idx = idx - NUM_VC;
      if (!found && eligible[idx[VC_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[VC_W-1:0];
      end
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    rr_next     = rr;
    served_next = served;
    grant_next  = '0;
    flit_next   = vc_flit[winner*FLIT_SIZE +: FLIT_SIZE];

    send   = (state == RUN) && (cnt != 4'd0) && found;
    // A credit beyond the downstream depth is spurious and dropped, even when
    // it coincides with a send.
    ret_ok = credit_return && (cnt < DEPTH);

    case ({send, ret_ok})
      2'b10:   cnt_next = cnt - 4'd1;
      2'b01:   cnt_next = cnt + 4'd1;
      default: cnt_next = cnt;
    endcase

    if (send) begin
      grant_next = {{(NUM_VC-1){1'b0}}, 1'b1} << winner;
      if (winner == VC_W'(NUM_VC - 1)) rr_next = '0;
      else                             rr_next = winner + VC_W'(1);
    end

    // is_new lingers after the grant; served masks that window until it drops.
    for (int i = 0; i < NUM_VC; i++) begin
      served_next[i] = vc_is_new[i] & (served[i] | grant_next[i]);
    end

    case (state)
      RUN:     if (cnt_next == 4'd0) state_next = BLOCKED;
      BLOCKED: if (cnt_next != 4'd0) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      cnt            <= DEPTH;
      rr             <= '0;
      served         <= '0;
      vc_grant       <= '0;
      flit_out       <= '0;
      flit_out_valid <= 1'b0;
      flit_out_vc    <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      rr             <= rr_next;
      served         <= served_next;
      vc_grant       <= grant_next;
      flit_out_valid <= send;
      if (send) begin
        flit_out    <= flit_next;
        flit_out_vc <= winner;
      end
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed scenarios with a grant
// scoreboard checked every cycle on the falling edge.
module tb_output_arbiter;

  localparam int NV = 4;
  localparam int FS = 8;
  localparam int VW = 2;
  localparam int EW = NV + VW + FS;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NV*FS-1:0]  vc_flit = '0;
  logic [NV-1:0]     vc_is_new = '0;
  logic              credit_return = 1'b0;
  logic [NV-1:0]     vc_grant;
  logic [FS-1:0]     flit_out;
  logic              flit_out_valid;
  logic [VW-1:0]     flit_out_vc;
  logic              dbg_state;
  logic [3:0]        dbg_cnt;

  logic [EW-1:0] exp_q[$];
  logic [FS-1:0] flit_mem [NV];
  int tests  = 0;
  int failed = 0;

  output_arbiter #(.NUM_VC(NV), .DOWNSTREAM_DEPTH(4), .FLIT_SIZE(FS)) dut (
    .clock(clock), .reset(reset), .vc_flit(vc_flit), .vc_is_new(vc_is_new),
    .credit_return(credit_return), .vc_grant(vc_grant), .flit_out(flit_out),
    .flit_out_valid(flit_out_valid), .flit_out_vc(flit_out_vc),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic set_flits();
    for (int i = 0; i < NV; i++) begin
      flit_mem[i] = 8'($urandom_range(0, 255));
      vc_flit[i*FS +: FS] = flit_mem[i];
    end
  endtask

  function automatic logic [EW-1:0] entry(int vc);
    logic [NV-1:0] g;
    g = NV'(1) << vc;
    return {g, VW'(vc), flit_mem[vc]};
  endfunction

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b1;
    vc_is_new = '0;
    credit_return = 1'b0;
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock: sample at the falling edge, pop the scoreboard on each grant.
  task automatic cycle();
    logic [EW-1:0] got, exp;
    @(negedge clock);
    got = {vc_grant, flit_out_vc, flit_out};
    tests++;
    if (dbg_state !== (dbg_cnt == 4'd0)) begin
      failed++;
      $display("FAIL state_vs_cnt: state=%0b cnt=%0d", dbg_state, dbg_cnt);
    end
    tests++;
    if (flit_out_valid) begin
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_grant: got grant=%b vc=%0d flit=%h, none expected",
                 vc_grant, flit_out_vc, flit_out);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failed++;
          $display("FAIL grant: got %h, expected %h", got, exp);
        end
      end
    end else if (vc_grant !== '0) begin
      failed++;
      $display("FAIL grant_without_valid: grant=%b", vc_grant);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clock);
    tests++;
    if ({vc_grant, flit_out, flit_out_valid, flit_out_vc} !== '0 ||
        dbg_cnt !== 4'd4 || dbg_state !== 1'b0) begin
      failed++;
      $display("FAIL reset_state: grant=%b flit=%h v=%b vc=%0d cnt=%0d st=%b, want zeros cnt=4 st=0",
               vc_grant, flit_out, flit_out_valid, flit_out_vc, dbg_cnt, dbg_state);
    end
  endtask

  task automatic test_single_vc();
    reset_dut();
    set_flits();
    vc_is_new = 4'b0100;
    exp_q.push_back(entry(2));
    cycle();
    tests++;
    if (dbg_cnt !== 4'd3) begin
      failed++;
      $display("FAIL single_cnt: got %0d, expected 3", dbg_cnt);
    end
    cycle();
    cycle();
    vc_is_new = '0;
    cycle();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL single_missing: %0d grants outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_all_and_blocked();
    reset_dut();
    set_flits();
    vc_is_new = 4'b1111;
    for (int i = 0; i < NV; i++) exp_q.push_back(entry(i));
    for (int i = 0; i < NV + 2; i++) cycle();
    tests++;
    if (dbg_cnt !== 4'd0 || dbg_state !== 1'b1 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL all_blocked: cnt=%0d st=%b left=%0d, expected cnt=0 st=1 left=0",
               dbg_cnt, dbg_state, exp_q.size());
    end
    // Credit return from BLOCKED releases exactly one grant to VC 1.
    vc_is_new = '0;
    cycle();
    vc_is_new = 4'b0010;
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    tests++;
    if (dbg_cnt !== 4'd1 || dbg_state !== 1'b0) begin
      failed++;
      $display("FAIL credit_unblock: cnt=%0d st=%b, expected cnt=1 st=0", dbg_cnt, dbg_state);
    end
    exp_q.push_back(entry(1));
    cycle();
    cycle();
    tests++;
    if (dbg_cnt !== 4'd0 || dbg_state !== 1'b1 || exp_q.size() != 0) begin
      failed++;
      $display("FAIL reblock: cnt=%0d st=%b left=%0d, expected cnt=0 st=1 left=0",
               dbg_cnt, dbg_state, exp_q.size());
    end
    vc_is_new = '0;
  endtask

  task automatic test_credit_edges();
    reset_dut();
    set_flits();
    vc_is_new = 4'b0011;
    exp_q.push_back(entry(0));
    exp_q.push_back(entry(1));
    cycle();
    cycle();
    vc_is_new = '0;
    cycle();
    tests++;
    if (dbg_cnt !== 4'd2) begin
      failed++;
      $display("FAIL two_sends_cnt: got %0d, expected 2", dbg_cnt);
    end
    vc_is_new = 4'b0100;
    credit_return = 1'b1;
    exp_q.push_back(entry(2));
    cycle();
    credit_return = 1'b0;
    tests++;
    if (dbg_cnt !== 4'd2) begin
      failed++;
      $display("FAIL send_and_return: cnt=%0d, expected 2", dbg_cnt);
    end
    vc_is_new = '0;
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    tests++;
    if (dbg_cnt !== 4'd3) begin
      failed++;
      $display("FAIL return_inc: cnt=%0d, expected 3", dbg_cnt);
    end
    reset_dut();
    credit_return = 1'b1;
    cycle();
    cycle();
    credit_return = 1'b0;
    tests++;
    if (dbg_cnt !== 4'd4) begin
      failed++;
      $display("FAIL return_at_full: cnt=%0d, expected 4", dbg_cnt);
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    set_flits();
    vc_is_new = 4'b0100;
    exp_q.push_back(entry(2));
    cycle();
    vc_is_new = '0;
    cycle();
    vc_is_new = 4'b1001;
    exp_q.push_back(entry(3));
    exp_q.push_back(entry(0));
    cycle();
    cycle();
    cycle();
    vc_is_new = '0;
    cycle();
    tests++;
    if (exp_q.size() != 0 || dbg_cnt !== 4'd1) begin
      failed++;
      $display("FAIL wrap: left=%0d cnt=%0d, expected left=0 cnt=1", exp_q.size(), dbg_cnt);
    end
  endtask

  task automatic test_random_rr();
    logic [NV-1:0] pat;
    int rr_m;
    reset_dut();
    rr_m = 0;
    for (int n = 0; n < 6; n++) begin
      set_flits();
      pat = NV'($urandom_range(1, 15));
      vc_is_new = pat;
      for (int k = 0; k < NV; k++) begin
        if (pat[(rr_m + k) % NV]) begin
          exp_q.push_back(entry((rr_m + k) % NV));
          rr_m = ((rr_m + k) % NV + 1) % NV;
          break;
        end
      end
      cycle();
      vc_is_new = '0;
      credit_return = 1'b1;
      cycle();
      credit_return = 1'b0;
    end
    tests++;
    if (exp_q.size() != 0 || dbg_cnt !== 4'd4) begin
      failed++;
      $display("FAIL random_rr: left=%0d cnt=%0d, expected left=0 cnt=4", exp_q.size(), dbg_cnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    reset_dut();
    set_flits();
    vc_is_new = 4'b0001;
    @(posedge clock);
    #1;
    tests++;
    if (flit_out_valid !== 1'b1 || vc_grant !== 4'b0001) begin
      failed++;
      $display("FAIL pre_reset_grant: v=%b grant=%b, expected 1 0001", flit_out_valid, vc_grant);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({vc_grant, flit_out, flit_out_valid, flit_out_vc} !== '0 || dbg_cnt !== 4'd4) begin
      failed++;
      $display("FAIL async_reset: grant=%b flit=%h v=%b vc=%0d cnt=%0d, expected zeros cnt=4",
               vc_grant, flit_out, flit_out_valid, flit_out_vc, dbg_cnt);
    end
    vc_is_new = '0;
    @(negedge clock);
    reset = 1'b0;
    cycle();
    cycle();
    tests++;
    if (dbg_cnt !== 4'd4) begin
      failed++;
      $display("FAIL cnt_after_reset: got %0d, expected 4", dbg_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_vc();
    test_all_and_blocked();
    test_credit_edges();
    test_wrap();
    test_random_rr();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
